// File: rtl/hazard_forward_unit_pkg.sv
// rtl/hazard_forward_unit_pkg.sv - shared encodings and match helper for the hazard/forward unit
package hazard_forward_unit_pkg;

    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_WB   = 2'b01;
    localparam logic [1:0] FWD_MEM  = 2'b10;

    localparam int RAW_CNT_W = 2;

    typedef enum logic {
        IDLE     = 1'b0,
        RAW_WAIT = 1'b1
    } hz_state_t;

    // x0 is hard-wired zero, so it never creates a dependency
    function automatic logic reg_hit(
        input logic [4:0] rs,
        input logic       use_rs,
        input logic [4:0] rd,
        input logic       regwrite
    );
        return use_rs && (rs != 5'd0) && regwrite && (rs == rd);
    endfunction

endpackage

// File: rtl/hazard_src_compare.sv
// rtl/hazard_src_compare.sv - hit flags and forward select for one ID-stage source operand
module hazard_src_compare
    import hazard_forward_unit_pkg::*;
(
    input  logic [4:0] rs,
    input  logic       use_rs,
    input  logic [4:0] rd_e,
    input  logic       regwrite_e,
    input  logic [4:0] rd_m,
    input  logic       regwrite_m,
    input  logic       mem_read_m,
    input  logic [4:0] rd_w,
    input  logic       regwrite_w,
    output logic       hit_e,
    output logic       hit_m,
    output logic [1:0] fwd
);

    logic hit_w;

    always_comb begin
        hit_e = reg_hit(rs, use_rs, rd_e, regwrite_e);
        hit_m = reg_hit(rs, use_rs, rd_m, regwrite_m);
        hit_w = reg_hit(rs, use_rs, rd_w, regwrite_w);
        // load data is not available in MEM, so a load hit there falls through to WB/regfile
        if (hit_m && !mem_read_m) begin
            fwd = FWD_MEM;
        end else if (hit_w) begin
            fwd = FWD_WB;
        end else begin
            fwd = FWD_NONE;
        end
    end

endmodule

// File: rtl/hazard_forward_unit.sv
// rtl/hazard_forward_unit.sv - ID/EX stall and operand-forward control with load-use timing FSM
module hazard_forward_unit
    import hazard_forward_unit_pkg::*;
#(
    parameter int STALL_CNT_W = 16
) (
    input  logic                   CLK,
    input  logic                   RESET_N,
    input  logic [4:0]             rs1_D,
    input  logic [4:0]             rs2_D,
    input  logic                   use_rs1_D,
    input  logic                   use_rs2_D,
    input  logic [4:0]             rd_E,
    input  logic                   regwrite_E,
    input  logic                   mem_read_E,
    input  logic [4:0]             rd_M,
    input  logic                   regwrite_M,
    input  logic                   mem_read_M,
    input  logic [4:0]             rd_W,
    input  logic                   regwrite_W,
    input  logic                   flush,
    output logic                   Stall,
    output logic [1:0]             ForwardA,
    output logic [1:0]             ForwardB,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    hz_state_t              state;
    logic [RAW_CNT_W-1:0]   cnt;
    logic                   hit_e1, hit_m1, hit_e2, hit_m2;
    logic [1:0]             fwd_a, fwd_b;
    logic                   req1, req2, stall_raw, stall_eff;

    hazard_src_compare u_cmp_rs1 (
        .rs         (rs1_D),
        .use_rs     (use_rs1_D),
        .rd_e       (rd_E),
        .regwrite_e (regwrite_E),
        .rd_m       (rd_M),
        .regwrite_m (regwrite_M),
        .mem_read_m (mem_read_M),
        .rd_w       (rd_W),
        .regwrite_w (regwrite_W),
        .hit_e      (hit_e1),
        .hit_m      (hit_m1),
        .fwd        (fwd_a)
    );

    hazard_src_compare u_cmp_rs2 (
        .rs         (rs2_D),
        .use_rs     (use_rs2_D),
        .rd_e       (rd_E),
        .regwrite_e (regwrite_E),
        .rd_m       (rd_M),
        .regwrite_m (regwrite_M),
        .mem_read_m (mem_read_M),
        .rd_w       (rd_W),
        .regwrite_w (regwrite_W),
        .hit_e      (hit_e2),
        .hit_m      (hit_m2),
        .fwd        (fwd_b)
    );

    // req1: one bubble suffices; req2: load in EX needs the extra RAW_WAIT cycle
    always_comb begin
        req1      = ((hit_e1 | hit_e2) & ~mem_read_E) | ((hit_m1 | hit_m2) & mem_read_M);
        req2      = (hit_e1 | hit_e2) & mem_read_E;
        stall_raw = req1 | req2 | (state == RAW_WAIT);
        stall_eff = stall_raw & ~flush;
    end

    // outputs are forced quiet while reset is held, independent of the inputs
    always_comb begin
        Stall    = stall_eff & RESET_N;
        ForwardA = (RESET_N && !flush) ? fwd_a : FWD_NONE;
        ForwardB = (RESET_N && !flush) ? fwd_b : FWD_NONE;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state        <= IDLE;
            cnt          <= '0;
            stall_cycles <= '0;
        end else begin
            if (stall_eff && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + STALL_CNT_W'(1);
            end
            if (flush) begin
                state <= IDLE;
                cnt   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (req2) begin
                            state <= RAW_WAIT;
                            cnt   <= RAW_CNT_W'(1);
                        end
                    end
                    RAW_WAIT: begin
                        if (cnt <= RAW_CNT_W'(1)) begin
                            state <= IDLE;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt - RAW_CNT_W'(1);
                        end
                    end
                    default: begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// tb/tb_hazard_forward_unit.sv - directed self-checking bench for hazard_forward_unit
module tb_hazard_forward_unit;

    localparam int W = 3;

    logic         CLK = 1'b0;
    logic         RESET_N;
    logic [4:0]   rs1_D, rs2_D, rd_E, rd_M, rd_W;
    logic         use_rs1_D, use_rs2_D;
    logic         regwrite_E, mem_read_E, regwrite_M, mem_read_M, regwrite_W;
    logic         flush;
    logic         Stall;
    logic [1:0]   ForwardA, ForwardB;
    logic [W-1:0] stall_cycles;

    int tests = 0;
    int fails = 0;

    always #5 CLK = ~CLK;

    hazard_forward_unit #(.STALL_CNT_W(W)) dut (
        .CLK          (CLK),
        .RESET_N      (RESET_N),
        .rs1_D        (rs1_D),
        .rs2_D        (rs2_D),
        .use_rs1_D    (use_rs1_D),
        .use_rs2_D    (use_rs2_D),
        .rd_E         (rd_E),
        .regwrite_E   (regwrite_E),
        .mem_read_E   (mem_read_E),
        .rd_M         (rd_M),
        .regwrite_M   (regwrite_M),
        .mem_read_M   (mem_read_M),
        .rd_W         (rd_W),
        .regwrite_W   (regwrite_W),
        .flush        (flush),
        .Stall        (Stall),
        .ForwardA     (ForwardA),
        .ForwardB     (ForwardB),
        .stall_cycles (stall_cycles)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        rs1_D = 5'd0; rs2_D = 5'd0; use_rs1_D = 1'b0; use_rs2_D = 1'b0;
        rd_E = 5'd0; regwrite_E = 1'b0; mem_read_E = 1'b0;
        rd_M = 5'd0; regwrite_M = 1'b0; mem_read_M = 1'b0;
        rd_W = 5'd0; regwrite_W = 1'b0; flush = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge CLK);
        #1;
        clear_inputs();
    endtask

    initial begin
        // reset held with an ALU hazard present: outputs must stay quiet
        RESET_N = 1'b0;
        clear_inputs();
        rd_E = 5'd7; regwrite_E = 1'b1; rs1_D = 5'd7; use_rs1_D = 1'b1;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("rst_stall", Stall, 0);
        check("rst_fwda", ForwardA, 0);
        check("rst_fwdb", ForwardB, 0);
        check("rst_cnt", stall_cycles, 0);
        @(posedge CLK); #1;
        RESET_N = 1'b1;
        clear_inputs();
        @(negedge CLK);
        check("idle_stall", Stall, 0);

        // ALU result in MEM feeds rs1
        next_cycle();
        rd_M = 5'd5; regwrite_M = 1'b1; rs1_D = 5'd5; use_rs1_D = 1'b1;
        @(negedge CLK);
        check("memfwd_fa", ForwardA, 2'b10);
        check("memfwd_stall", Stall, 0);
        check("memfwd_cnt", stall_cycles, 0);

        // load-use on rs2: two stall cycles, then WB forward
        next_cycle();
        rd_E = 5'd6; regwrite_E = 1'b1; mem_read_E = 1'b1; rs2_D = 5'd6; use_rs2_D = 1'b1;
        @(negedge CLK);
        check("ld_stall1", Stall, 1);
        next_cycle();
        rd_M = 5'd6; regwrite_M = 1'b1; mem_read_M = 1'b1; rs2_D = 5'd6; use_rs2_D = 1'b1;
        @(negedge CLK);
        check("ld_stall2", Stall, 1);
        check("ld_fwdb_mem_load", ForwardB, 2'b00);
        next_cycle();
        rd_W = 5'd6; regwrite_W = 1'b1; rs2_D = 5'd6; use_rs2_D = 1'b1;
        @(negedge CLK);
        check("ld_stall3", Stall, 0);
        check("ld_fwdb", ForwardB, 2'b01);
        check("ld_cnt", stall_cycles, 2);

        // ALU producer in EX: one stall, then MEM forward
        next_cycle();
        rd_E = 5'd7; regwrite_E = 1'b1; rs1_D = 5'd7; use_rs1_D = 1'b1;
        @(negedge CLK);
        check("alu_stall1", Stall, 1);
        next_cycle();
        rd_M = 5'd7; regwrite_M = 1'b1; rs1_D = 5'd7; use_rs1_D = 1'b1;
        @(negedge CLK);
        check("alu_stall2", Stall, 0);
        check("alu_fa", ForwardA, 2'b10);
        check("alu_cnt", stall_cycles, 3);

        // MEM has priority over WB
        next_cycle();
        rd_M = 5'd9; regwrite_M = 1'b1; rd_W = 5'd9; regwrite_W = 1'b1;
        rs1_D = 5'd9; rs2_D = 5'd9; use_rs1_D = 1'b1; use_rs2_D = 1'b1;
        @(negedge CLK);
        check("prio_fa", ForwardA, 2'b10);
        check("prio_fb", ForwardB, 2'b10);
        check("prio_stall", Stall, 0);

        // x0 never matches; unused source never matches
        next_cycle();
        rd_E = 5'd0; regwrite_E = 1'b1; rd_M = 5'd0; regwrite_M = 1'b1;
        rs1_D = 5'd0; use_rs1_D = 1'b1;
        rd_W = 5'd12; regwrite_W = 1'b1; rs2_D = 5'd12; use_rs2_D = 1'b0;
        @(negedge CLK);
        check("x0_stall", Stall, 0);
        check("x0_fa", ForwardA, 2'b00);
        check("nouse_fb", ForwardB, 2'b00);

        // rs1 load in EX, rs2 ALU in MEM: independent selects, max depth
        next_cycle();
        rd_E = 5'd4; regwrite_E = 1'b1; mem_read_E = 1'b1; rs1_D = 5'd4; use_rs1_D = 1'b1;
        rd_M = 5'd8; regwrite_M = 1'b1; rs2_D = 5'd8; use_rs2_D = 1'b1;
        @(negedge CLK);
        check("dual_stall1", Stall, 1);
        check("dual_fb1", ForwardB, 2'b10);
        next_cycle();
        rd_M = 5'd4; regwrite_M = 1'b1; mem_read_M = 1'b1; rs1_D = 5'd4; use_rs1_D = 1'b1;
        rd_W = 5'd8; regwrite_W = 1'b1; rs2_D = 5'd8; use_rs2_D = 1'b1;
        @(negedge CLK);
        check("dual_stall2", Stall, 1);
        check("dual_fb2", ForwardB, 2'b01);
        check("dual_fa2", ForwardA, 2'b00);
        next_cycle();
        rd_W = 5'd4; regwrite_W = 1'b1; rs1_D = 5'd4; use_rs1_D = 1'b1;
        @(negedge CLK);
        check("dual_stall3", Stall, 0);
        check("dual_fa3", ForwardA, 2'b01);
        check("dual_cnt", stall_cycles, 5);

        // flush in the RAW_WAIT cycle kills the stall and the forward
        next_cycle();
        rd_E = 5'd3; regwrite_E = 1'b1; mem_read_E = 1'b1; rs1_D = 5'd3; use_rs1_D = 1'b1;
        @(negedge CLK);
        check("fl_stall1", Stall, 1);
        next_cycle();
        flush = 1'b1; rd_W = 5'd3; regwrite_W = 1'b1; rs1_D = 5'd3; use_rs1_D = 1'b1;
        @(negedge CLK);
        check("fl_stall2", Stall, 0);
        check("fl_fa", ForwardA, 2'b00);
        next_cycle();
        @(negedge CLK);
        check("fl_idle_stall", Stall, 0);
        check("fl_cnt", stall_cycles, 6);

        // reset mid-stall ends it immediately and clears the counter
        next_cycle();
        rd_E = 5'd3; regwrite_E = 1'b1; mem_read_E = 1'b1; rs1_D = 5'd3; use_rs1_D = 1'b1;
        @(negedge CLK);
        check("rs_stall1", Stall, 1);
        next_cycle();
        #2;
        check("rs_wait_stall", Stall, 1);
        check("rs_cnt_before", stall_cycles, 7);
        RESET_N = 1'b0;
        #1;
        check("rs_stall_async", Stall, 0);
        check("rs_cnt_async", stall_cycles, 0);
        @(posedge CLK); #1;
        RESET_N = 1'b1;
        @(negedge CLK);
        check("rs_after_stall", Stall, 0);

        // held ALU hazard: counter saturates at all-ones
        next_cycle();
        rd_E = 5'd7; regwrite_E = 1'b1; rs1_D = 5'd7; use_rs1_D = 1'b1;
        repeat (6) @(posedge CLK);
        @(negedge CLK);
        check("sat_cnt6", stall_cycles, 6);
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("sat_cnt7", stall_cycles, 7);
        check("sat_stall", Stall, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
